// File: rtl/unsigned_16d8_seq_div.sv
// Sequential unsigned restoring divider: a 2*DW-bit dividend divided by a DW-bit divisor,
// one quotient bit per clock, with valid/ready handshakes on the operand and result sides.
module unsigned_16d8_seq_div #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_zero
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and the result is held until taken.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(2 * DW + 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [2*DW-1:0] shift_reg;
    logic [DW:0]     partial_rem;
    logic [DW-1:0]   divisor_q;

    logic [DW+1:0]   rem_shift;
    logic [DW+1:0]   trial;
    logic            trial_neg;
    logic [DW:0]     rem_next;
    logic [2*DW-1:0] shift_next;
    logic            accept;
    logic            last_iter;

    assign accept    = (state == IDLE) && in_valid;
    assign last_iter = (state == BUSY) && (count == CW'(1));

    // One restoring step: shift the next dividend bit into the remainder, trial-subtract.
    always_comb begin
        rem_shift  = {partial_rem, shift_reg[2*DW-1]};
        trial      = rem_shift - {2'b00, divisor_q};
        trial_neg  = trial[DW+1];
        rem_next   = trial_neg ? rem_shift[DW:0] : trial[DW:0];
        shift_next = {shift_reg[2*DW-2:0], ~trial_neg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Result registers change only on accept or the final iteration, so they stay stable in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            shift_reg   <= '0;
            partial_rem <= '0;
            divisor_q   <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_zero    <= 1'b0;
        end else if (accept) begin
            divisor_q <= divisor;
            div_zero  <= (divisor == '0);
            if (divisor == '0) begin
                quotient  <= '1;
                remainder <= '1;
                count     <= '0;
            end else begin
                partial_rem <= '0;
                shift_reg   <= dividend;
                count       <= CW'(2 * DW);
            end
        end else if (state == BUSY) begin
            partial_rem <= rem_next;
            shift_reg   <= shift_next;
            count       <= count - CW'(1);
            if (last_iter) begin
                quotient  <= shift_next;
                remainder <= rem_next[DW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_unsigned_16d8_seq_div.sv
// Directed bench for unsigned_16d8_seq_div: exact and remainder cases, divide by zero,
// backpressure, reset mid-operation and operand round-trips.
module tb_unsigned_16d8_seq_div;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2*DW-1:0] dividend = '0;
    logic [DW-1:0]   divisor = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*DW-1:0] quotient;
    logic [DW-1:0]   remainder;
    logic            div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    unsigned_16d8_seq_div #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Latency is counted in edges after the accept edge at which out_valid is first seen.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input logic edz,
                          input int elat, input int hold, input bit early, input bit poke);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        out_ready = early;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
            if (n == 3) check({tag, " busy in_ready"}, 32'(in_ready), 32'd0);
            if (poke) begin
                in_valid = 1'b1;
                dividend = 16'($urandom_range(0, 65535));
                divisor  = 8'($urandom_range(0, 255));
            end
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(elat));
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_zero"}, 32'(div_zero), 32'(edz));
        check({tag, " done in_ready"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold quotient"}, 32'(quotient), 32'(eq));
            check({tag, " hold remainder"}, 32'(remainder), 32'(er));
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " post out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " post in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  x;

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset div_zero", 32'(div_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("50000/200", 16'd50000, 8'd200, 16'd250, 8'd0, 1'b0, 17, 0, 1'b0, 1'b0);
        run_op("65025/255", 16'd65025, 8'd255, 16'd255, 8'd0, 1'b0, 17, 0, 1'b1, 1'b0);
        run_op("12345/7", 16'd12345, 8'd7, 16'd1763, 8'd4, 1'b0, 17, 0, 1'b0, 1'b1);
        run_op("65535/1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 17, 0, 1'b0, 1'b0);
        run_op("0/9", 16'd0, 8'd9, 16'd0, 8'd0, 1'b0, 17, 0, 1'b0, 1'b0);
        run_op("1234/0", 16'd1234, 8'd0, 16'hFFFF, 8'hFF, 1'b1, 1, 0, 1'b0, 1'b0);
        run_op("1000/3", 16'd1000, 8'd3, 16'd333, 8'd1, 1'b0, 17, 5, 1'b0, 1'b0);

        // Abort an operation partway through its iterations.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset quotient", 32'(quotient), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("300/17", 16'd300, 8'd17, 16'd17, 8'd11, 1'b0, 17, 0, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 8'($urandom_range(1, 255));
            run_op("random", a, b, a / 16'(b), 8'(a % 16'(b)), 1'b0, 17, 0, i[0], 1'b0);
        end

        for (int i = 0; i < 150; i++) begin
            x = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            a = 16'(x) * 16'(b);
            run_op("product", a, b, 16'(x), 8'd0, 1'b0, 17, 0, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
